// File: rtl/taxi_qspi_flash_target.sv
// QSPI flash target (responder) serving read-only commands from a byte-wide memory port.
// All QSPI pins are oversampled in the clk domain; clk must run at least 8x qspi_clk.
//
// Ports:
//   clk          local clock
//   rst_n        asynchronous active-low reset (released synchronously inside)
//   qspi_clk     SCK from controller, mode 0
//   qspi_cs      chip select, active low
//   qspi_dq_i    DQ from controller (dq[0] = MOSI)
//   qspi_dq_o    DQ driven by target
//   qspi_dq_oe   per-bit output enable
//   mem_addr     memory read address
//   mem_rd_en    memory read strobe, one cycle per byte
//   mem_rd_data  memory read data, valid one clk after mem_rd_en
//   busy         a supported command is selected
//   cmd_err      one-cycle pulse on unsupported opcode
module taxi_qspi_flash_target #(
   parameter int unsigned ADDR_W    = 24,
   parameter logic [23:0] JEDEC_ID  = 24'h20BB20,
   parameter int unsigned DUMMY_CYC = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              qspi_clk,
   input  logic              qspi_cs,
   input  logic [3:0]        qspi_dq_i,
   output logic [3:0]        qspi_dq_o,
   output logic [3:0]        qspi_dq_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rd_data,
   output logic              busy,
   output logic              cmd_err
);

   localparam int unsigned CntW = $clog2(ADDR_W + DUMMY_CYC + 8);

   localparam logic [7:0] OpReadId = 8'h9F;
   localparam logic [7:0] OpStatus = 8'h05;
   localparam logic [7:0] OpRead   = 8'h03;
   localparam logic [7:0] OpFast   = 8'h0B;
   localparam logic [7:0] OpQuad   = 8'h6B;

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StDummy, StData, StIgnore
   } state_e;

   // Reset: asynchronous assert, two-flop synchronous release.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_int_n = rst_sync_q[1];

   // Pin synchronizers; sck keeps a third stage for edge detection.
   logic [2:0]      sck_sync_q;
   logic [1:0]      cs_sync_q;
   logic [1:0][3:0] dq_sync_q;
   logic            cs_s, sck_rise, sck_fall;
   logic [3:0]      dq_s;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sck_sync_q <= '0;
         cs_sync_q  <= '0;  // low until seen high, so a transaction in flight is not armed
         dq_sync_q  <= '0;
      end else begin
         sck_sync_q <= {sck_sync_q[1:0], qspi_clk};
         cs_sync_q  <= {cs_sync_q[0], qspi_cs};
         dq_sync_q  <= {dq_sync_q[0], qspi_dq_i};
      end
   end

   assign cs_s     = cs_sync_q[1];
   assign dq_s     = dq_sync_q[1];
   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];

   // All supported commands shift in on dq[0]; the other input lanes are never sampled.
   logic unused_dq;
   assign unused_dq = ^dq_s[3:1];

   state_e            state_q, state_d;
   logic              armed_q, armed_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        cmd_sh_q, cmd_sh_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic              rd_pend_q, rd_pend_d;
   logic [7:0]        byte_q, byte_d;     // next byte to send
   logic [7:0]        tx_q, tx_d;         // byte being shifted out
   logic [2:0]        tx_cnt_q, tx_cnt_d; // shifts left in tx_q; 0 means load byte_q next
   logic [1:0]        id_idx_q, id_idx_d;
   logic [3:0]        dq_o_q, dq_o_d;
   logic [3:0]        dq_oe_q, dq_oe_d;
   logic              cmd_err_q, cmd_err_d;
   logic [7:0]        opcode;
   logic              quad;

   assign opcode = {cmd_sh_q[6:0], dq_s[0]};
   assign quad   = (op_q == OpQuad);

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= StIdle;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         cmd_sh_q    <= '0;
         op_q        <= '0;
         addr_sh_q   <= '0;
         mem_addr_q  <= '0;
         mem_rd_en_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         byte_q      <= '0;
         tx_q        <= '0;
         tx_cnt_q    <= '0;
         id_idx_q    <= '0;
         dq_o_q      <= '0;
         dq_oe_q     <= '0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         cmd_sh_q    <= cmd_sh_d;
         op_q        <= op_d;
         addr_sh_q   <= addr_sh_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_en_q <= mem_rd_en_d;
         rd_pend_q   <= rd_pend_d;
         byte_q      <= byte_d;
         tx_q        <= tx_d;
         tx_cnt_q    <= tx_cnt_d;
         id_idx_q    <= id_idx_d;
         dq_o_q      <= dq_o_d;
         dq_oe_q     <= dq_oe_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      cnt_d       = cnt_q;
      cmd_sh_d    = cmd_sh_q;
      op_d        = op_q;
      addr_sh_d   = addr_sh_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_en_d = 1'b0;
      rd_pend_d   = mem_rd_en_q;
      byte_d      = rd_pend_q ? mem_rd_data : byte_q;
      tx_d        = tx_q;
      tx_cnt_d    = tx_cnt_q;
      id_idx_d    = id_idx_q;
      dq_o_d      = dq_o_q;
      dq_oe_d     = dq_oe_q;
      cmd_err_d   = 1'b0;

      // cs high overrides everything, including a coincident SCK edge.
      if (cs_s) begin
         state_d = StIdle;
         armed_d = 1'b1;
         dq_o_d  = '0;
         dq_oe_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (armed_q) begin
                  state_d = StCmd;
                  cnt_d   = '0;
               end
            end
            StCmd: begin
               if (sck_rise) begin
                  cmd_sh_d = opcode;
                  cnt_d    = cnt_q + CntW'(1);
                  if (cnt_q == CntW'(7)) begin
                     op_d  = opcode;
                     cnt_d = '0;
                     case (opcode)
                        OpReadId: begin
                           state_d  = StData;
                           byte_d   = JEDEC_ID[23:16];
                           id_idx_d = 2'd1;
                           tx_cnt_d = '0;
                           dq_oe_d  = 4'b0010;
                        end
                        OpStatus: begin
                           state_d  = StData;
                           byte_d   = 8'h00;
                           tx_cnt_d = '0;
                           dq_oe_d  = 4'b0010;
                        end
                        OpRead, OpFast, OpQuad: state_d = StAddr;
                        default: begin
                           state_d   = StIgnore;
                           cmd_err_d = 1'b1;
                        end
                     endcase
                  end
               end
            end
            StAddr: begin
               if (sck_rise) begin
                  addr_sh_d = {addr_sh_q[ADDR_W-2:0], dq_s[0]};
                  cnt_d     = cnt_q + CntW'(1);
                  if (cnt_q == CntW'(ADDR_W - 1)) begin
                     mem_addr_d  = addr_sh_d;
                     mem_rd_en_d = 1'b1;
                     cnt_d       = '0;
                     if (op_q == OpRead || DUMMY_CYC == 0) begin
                        state_d  = StData;
                        tx_cnt_d = '0;
                        dq_oe_d  = quad ? 4'hF : 4'b0010;
                     end else begin
                        state_d = StDummy;
                     end
                  end
               end
            end
            StDummy: begin
               if (sck_rise) begin
                  cnt_d = cnt_q + CntW'(1);
                  if (cnt_q == CntW'(DUMMY_CYC - 1)) begin
                     state_d  = StData;
                     tx_cnt_d = '0;
                     dq_oe_d  = quad ? 4'hF : 4'b0010;
                  end
               end
            end
            StData: begin
               if (sck_fall) begin
                  if (tx_cnt_q == 3'd0) begin
                     if (quad) begin
                        dq_o_d   = byte_q[7:4];
                        tx_d     = {byte_q[3:0], 4'h0};
                        tx_cnt_d = 3'd1;
                     end else begin
                        dq_o_d   = {2'b00, byte_q[7], 1'b0};
                        tx_d     = {byte_q[6:0], 1'b0};
                        tx_cnt_d = 3'd7;
                     end
                     // Byte consumed: stage the following one.
                     if (op_q == OpReadId) begin
                        unique case (id_idx_q)
                           2'd1:    byte_d = JEDEC_ID[15:8];
                           2'd2:    byte_d = JEDEC_ID[7:0];
                           default: byte_d = 8'h00;
                        endcase
                        if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                     end else if (op_q == OpStatus) begin
                        byte_d = 8'h00;
                     end else begin
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_rd_en_d = 1'b1;
                     end
                  end else begin
                     if (quad) begin
                        dq_o_d = tx_q[7:4];
                        tx_d   = {tx_q[3:0], 4'h0};
                     end else begin
                        dq_o_d = {2'b00, tx_q[7], 1'b0};
                        tx_d   = {tx_q[6:0], 1'b0};
                     end
                     tx_cnt_d = tx_cnt_q - 3'd1;
                  end
               end
            end
            StIgnore: ;
            default: state_d = StIdle;
         endcase
      end
   end

   assign qspi_dq_o  = dq_o_q;
   assign qspi_dq_oe = dq_oe_q;
   assign mem_addr   = mem_addr_q;
   assign mem_rd_en  = mem_rd_en_q;
   assign cmd_err    = cmd_err_q;
   assign busy       = (state_q == StCmd) || (state_q == StAddr) ||
                       (state_q == StDummy) || (state_q == StData);

endmodule

// File: tb/tb_taxi_qspi_flash_target.sv
// Directed bench for taxi_qspi_flash_target: acts as the QSPI controller at clk/8 and models a
// memory returning addr[7:0]^0x5A one clk after each read strobe.
module tb_taxi_qspi_flash_target;

   localparam int HALF = 4;  // clk cycles per SCK half period (8x oversampling)

   logic        clk = 1'b0;
   logic        rst_n;
   logic        qspi_clk;
   logic        qspi_cs;
   logic [3:0]  qspi_dq_i;
   logic [3:0]  qspi_dq_o;
   logic [3:0]  qspi_dq_oe;
   logic [23:0] mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_rd_data = 8'h00;
   logic        busy;
   logic        cmd_err;

   int          total = 0;
   int          bad = 0;
   int          err_cnt = 0;
   logic [23:0] rd_log[$];
   logic [3:0]  oe_acc;

   taxi_qspi_flash_target dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .qspi_clk   (qspi_clk),
      .qspi_cs    (qspi_cs),
      .qspi_dq_i  (qspi_dq_i),
      .qspi_dq_o  (qspi_dq_o),
      .qspi_dq_oe (qspi_dq_oe),
      .mem_addr   (mem_addr),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_data(mem_rd_data),
      .busy       (busy),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem_addr[7:0] ^ 8'h5A;
         rd_log.push_back(mem_addr);
      end
      if (cmd_err) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One SCK period; target output is sampled just before the rising edge.
   task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout);
      qspi_dq_i = din;
      repeat (HALF) @(negedge clk);
      dout   = qspi_dq_o;
      oe_acc = oe_acc | qspi_dq_oe;
      qspi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      qspi_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [23:0] v, input int n);
      logic [3:0] d;
      for (int i = n - 1; i >= 0; i--) sck_cycle({3'b000, v[i]}, d);
   endtask

   task automatic idle_cycles(input int n);
      logic [3:0] d;
      for (int i = 0; i < n; i++) sck_cycle(4'h0, d);
   endtask

   task automatic read_single(output logic [7:0] b);
      logic [3:0] d;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         sck_cycle(4'h0, d);
         b = {b[6:0], d[1]};
      end
   endtask

   task automatic read_quad(output logic [7:0] b);
      logic [3:0] d;
      b = '0;
      for (int i = 0; i < 2; i++) begin
         sck_cycle(4'h0, d);
         b = {b[3:0], d};
      end
   endtask

   task automatic cs_low();
      qspi_cs = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_high();
      qspi_dq_i = 4'h0;
      qspi_cs   = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      rst_n     = 1'b0;
      qspi_clk  = 1'b0;
      qspi_cs   = 1'b1;
      qspi_dq_i = 4'h0;
      oe_acc    = 4'h0;
      repeat (3) @(negedge clk);

      chk("rst_dq_o", {28'h0, qspi_dq_o}, 32'h0);
      chk("rst_oe", {28'h0, qspi_dq_oe}, 32'h0);
      chk("rst_addr", {8'h0, mem_addr}, 32'h0);
      chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_cmd_err", {31'h0, cmd_err}, 32'h0);

      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 32'h0);

      // T1: READ ID
      cs_low();
      chk("t1_busy", {31'h0, busy}, 32'h1);
      oe_acc = 4'h0;
      send_bits(24'h9F, 8);
      chk("t1_oe_cmd", {28'h0, oe_acc}, 32'h0);
      oe_acc = 4'h0;
      read_single(b); chk("t1_id0", {24'h0, b}, 32'h20);
      read_single(b); chk("t1_id1", {24'h0, b}, 32'hBB);
      read_single(b); chk("t1_id2", {24'h0, b}, 32'h20);
      read_single(b); chk("t1_id3", {24'h0, b}, 32'h00);
      chk("t1_oe_data", {28'h0, oe_acc}, 32'h2);
      cs_high();
      chk("t1_no_rd", rd_log.size(), 32'd0);
      chk("t1_busy_end", {31'h0, busy}, 32'h0);
      chk("t1_oe_end", {28'h0, qspi_dq_oe}, 32'h0);

      // T2: READ 0x000100, 4 bytes
      rd_log.delete();
      cs_low();
      send_bits(24'h03, 8);
      send_bits(24'h000100, 24);
      oe_acc = 4'h0;
      read_single(b); chk("t2_d0", {24'h0, b}, 32'h5A);
      read_single(b); chk("t2_d1", {24'h0, b}, 32'h5B);
      read_single(b); chk("t2_d2", {24'h0, b}, 32'h58);
      read_single(b); chk("t2_d3", {24'h0, b}, 32'h59);
      chk("t2_oe", {28'h0, oe_acc}, 32'h2);
      cs_high();
      chk("t2_nrd", rd_log.size(), 32'd5);
      for (int i = 0; i < 5; i++) chk("t2_addr", {8'h0, rd_log[i]}, 32'h100 + i);

      // T3: QUAD OUTPUT READ at 0xFFFFFE across the wrap
      rd_log.delete();
      cs_low();
      send_bits(24'h6B, 8);
      send_bits(24'hFFFFFE, 24);
      oe_acc = 4'h0;
      idle_cycles(8);
      chk("t3_oe_dummy", {28'h0, oe_acc}, 32'h0);
      oe_acc = 4'h0;
      read_quad(b); chk("t3_d0", {24'h0, b}, 32'hA4);
      read_quad(b); chk("t3_d1", {24'h0, b}, 32'hA5);
      read_quad(b); chk("t3_d2", {24'h0, b}, 32'h5A);
      read_quad(b); chk("t3_d3", {24'h0, b}, 32'h5B);
      chk("t3_oe", {28'h0, oe_acc}, 32'hF);
      cs_high();
      chk("t3_nrd", rd_log.size(), 32'd5);
      chk("t3_a0", {8'h0, rd_log[0]}, 32'hFFFFFE);
      chk("t3_a1", {8'h0, rd_log[1]}, 32'hFFFFFF);
      chk("t3_a2", {8'h0, rd_log[2]}, 32'h000000);
      chk("t3_a3", {8'h0, rd_log[3]}, 32'h000001);

      // T4: unsupported opcode, then READ STATUS
      rd_log.delete();
      cs_low();
      send_bits(24'hAB, 8);
      oe_acc = 4'h0;
      idle_cycles(16);
      chk("t4_oe_ign", {28'h0, oe_acc}, 32'h0);
      chk("t4_err_cnt", err_cnt, 32'd1);
      chk("t4_busy_ign", {31'h0, busy}, 32'h0);
      cs_high();
      cs_low();
      send_bits(24'h05, 8);
      oe_acc = 4'h0;
      read_single(b); chk("t4_st0", {24'h0, b}, 32'h00);
      read_single(b); chk("t4_st1", {24'h0, b}, 32'h00);
      chk("t4_oe_st", {28'h0, oe_acc}, 32'h2);
      cs_high();
      chk("t4_no_rd", rd_log.size(), 32'd0);

      // T5: abort mid-address
      cs_low();
      send_bits(24'h03, 8);
      send_bits(24'h000003, 10);
      qspi_cs = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_busy", {31'h0, busy}, 32'h0);
      chk("t5_oe", {28'h0, qspi_dq_oe}, 32'h0);
      repeat (5) @(negedge clk);
      chk("t5_no_rd", rd_log.size(), 32'd0);
      cs_low();
      send_bits(24'h9F, 8);
      read_single(b); chk("t5_id0", {24'h0, b}, 32'h20);
      read_single(b); chk("t5_id1", {24'h0, b}, 32'hBB);
      read_single(b); chk("t5_id2", {24'h0, b}, 32'h20);
      cs_high();

      // T6: reset mid-data, release with cs low, then FAST READ
      cs_low();
      send_bits(24'h03, 8);
      send_bits(24'h000010, 24);
      read_single(b); chk("t6_d0", {24'h0, b}, 32'h4A);
      idle_cycles(3);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_oe", {28'h0, qspi_dq_oe}, 32'h0);
      chk("t6_rst_dq", {28'h0, qspi_dq_o}, 32'h0);
      chk("t6_rst_busy", {31'h0, busy}, 32'h0);
      chk("t6_rst_addr", {8'h0, mem_addr}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      rd_log.delete();
      oe_acc = 4'h0;
      send_bits(24'h9F, 8);
      idle_cycles(8);
      chk("t6_unarmed_oe", {28'h0, oe_acc}, 32'h0);
      chk("t6_unarmed_busy", {31'h0, busy}, 32'h0);
      cs_high();
      cs_low();
      send_bits(24'h0B, 8);
      send_bits(24'h000020, 24);
      oe_acc = 4'h0;
      idle_cycles(8);
      chk("t6_oe_dummy", {28'h0, oe_acc}, 32'h0);
      oe_acc = 4'h0;
      read_single(b); chk("t6_f0", {24'h0, b}, 32'h7A);
      read_single(b); chk("t6_f1", {24'h0, b}, 32'h7B);
      chk("t6_oe", {28'h0, oe_acc}, 32'h2);
      cs_high();
      chk("t6_a0", {8'h0, rd_log[0]}, 32'h20);
      chk("t6_nrd", rd_log.size(), 32'd3);
      chk("end_err_cnt", err_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
